seq_run_ctrl: RTL and testbench

//  Command sequencer for the Fibonacci and timer datapaths.

---
 rtl/seq_ctrl_pkg.sv | 18 +
 rtl/seq_prescaler.sv | 27 ++
 rtl/seq_run_ctrl.sv | 111 +++++++++++
 tb/tb_seq_run_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the run sequencer: state encoding and
// bit positions inside the status LED vector.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR_F = 3'd1,
        ST_RUN_F = 3'd2,
        ST_CLR_T = 3'd3,
        ST_RUN_T = 3'd4
    } state_t;

    localparam int LED_RUN_F   = 5;
    localparam int LED_RUN_T   = 4;
    localparam int LED_STOPPED = 3;
    localparam int LED_PROG_HI = 2;

endpackage

// File: rtl/seq_prescaler.sv
// Step-rate prescaler: counts while enabled, wraps at term and flags the
// wrap cycle; synchronous clear restarts the period from zero.
module seq_prescaler #(
    parameter int CNT_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    assign hit = en && (cnt == term);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= hit ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_run_ctrl.sv
// Command sequencer for the Fibonacci and timer datapaths: runs one datapath
// at a time and paces its step enables from a programmable prescaler.
module seq_run_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int DIV_BASE = 4,
    parameter int CNT_W    = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_f,
    input  logic       start_t,
    input  logic       stop_f_t,
    input  logic       update,
    input  logic [2:0] prog,
    input  logic       f_ovf,
    input  logic       t_done,
    output logic       f_clr,
    output logic       f_en,
    output logic       t_clr,
    output logic       t_en,
    output logic       sel_t,
    output logic [5:0] led
);

    state_t           state, state_nx;
    logic [2:0]       prog_q;
    logic             sel_q;
    logic             stopped;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] cnt;
    logic             hit;

    logic run_f, run_t, clr_any;
    logic idle_upd, idle_sf, idle_st, run_stop, run_end;

    assign run_f   = (state == ST_RUN_F);
    assign run_t   = (state == ST_RUN_T);
    assign clr_any = (state == ST_CLR_F) || (state == ST_CLR_T);

    // Priority on a shared edge: stop > update > start_f > start_t.
    assign idle_upd = (state == ST_IDLE) && !stop_f_t && update;
    assign idle_sf  = (state == ST_IDLE) && !stop_f_t && !update && start_f;
    assign idle_st  = (state == ST_IDLE) && !stop_f_t && !update && !start_f && start_t;
    assign run_stop = (run_f || run_t) && stop_f_t;
    assign run_end  = (run_f && f_ovf) || (run_t && t_done);

    // Computed in CNT_W bits so prog=7 still yields DIV_BASE*128-1.
    assign term = (CNT_W'(DIV_BASE) << prog_q) - CNT_W'(1);

    seq_prescaler #(.CNT_W(CNT_W)) u_presc (
        .clock (clock),
        .reset (reset),
        .clr   (clr_any),
        .en    (run_f || run_t),
        .term  (term),
        .cnt   (cnt),
        .hit   (hit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (idle_sf)      state_nx = ST_CLR_F;
                else if (idle_st) state_nx = ST_CLR_T;
            end
            ST_CLR_F: state_nx = ST_RUN_F;
            ST_CLR_T: state_nx = ST_RUN_T;
            ST_RUN_F: if (stop_f_t || f_ovf)  state_nx = ST_IDLE;
            ST_RUN_T: if (stop_f_t || t_done) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prog_q  <= '0;
            sel_q   <= 1'b0;
            stopped <= 1'b0;
        end else begin
            if (idle_upd) prog_q <= prog;
            if (idle_sf)      sel_q <= 1'b0;
            else if (idle_st) sel_q <= 1'b1;
            if (clr_any)       stopped <= 1'b0;
            else if (run_stop) stopped <= 1'b1;
            else if (run_end)  stopped <= 1'b0;
        end
    end

    // Outputs come only from registered state, never straight from inputs.
    assign f_clr = (state == ST_CLR_F);
    assign t_clr = (state == ST_CLR_T);
    assign f_en  = run_f && hit;
    assign t_en  = run_t && hit;
    assign sel_t = sel_q;

    always_comb begin
        led                        = '0;
        led[LED_RUN_F]             = run_f;
        led[LED_RUN_T]             = run_t;
        led[LED_STOPPED]           = stopped;
        led[LED_PROG_HI:0]         = prog_q;
    end

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Directed plus randomized bench for seq_run_ctrl, checked every cycle
// against a run/elapsed-time model of the sequencer.
module tb_seq_run_ctrl;

    localparam int DIV_BASE = 4;
    localparam int CNT_W    = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_f = 1'b0, start_t = 1'b0, stop_f_t = 1'b0, update = 1'b0;
    logic [2:0] prog = '0;
    logic       f_ovf = 1'b0, t_done = 1'b0;
    logic       f_clr, f_en, t_clr, t_en, sel_t;
    logic [5:0] led;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: phase 0 = idle, 1 = clearing, 2 = running; kind 0 = fib, 1 = timer.
    int   m_phase, m_kind, m_elapsed;
    int   m_prog;
    logic m_sel, m_stopped;

    seq_run_ctrl #(.DIV_BASE(DIV_BASE), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start_f(start_f), .start_t(start_t),
        .stop_f_t(stop_f_t), .update(update), .prog(prog), .f_ovf(f_ovf),
        .t_done(t_done), .f_clr(f_clr), .f_en(f_en), .t_clr(t_clr),
        .t_en(t_en), .sel_t(sel_t), .led(led)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_phase = 0; m_kind = 0; m_elapsed = 0;
        m_prog = 0; m_sel = 1'b0; m_stopped = 1'b0;
    endtask

    task automatic model_step(input logic sf, st, sp, up, input logic [2:0] pg,
                              input logic ov, dn);
        case (m_phase)
            0: begin
                if (sp) ;
                else if (up) m_prog = int'(pg);
                else if (sf) begin m_phase = 1; m_kind = 0; m_sel = 1'b0; end
                else if (st) begin m_phase = 1; m_kind = 1; m_sel = 1'b1; end
            end
            1: begin m_phase = 2; m_elapsed = 0; m_stopped = 1'b0; end
            default: begin
                if (sp) begin m_phase = 0; m_stopped = 1'b1; end
                else if ((m_kind == 0 && ov) || (m_kind == 1 && dn)) begin
                    m_phase = 0; m_stopped = 1'b0;
                end else m_elapsed++;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s at %0t: got %b want %b", tag, $time, got, want);
        end
    endtask

    task automatic check_all();
        int   period;
        logic en_due;
        logic [5:0] exp_led;
        period  = DIV_BASE << m_prog;
        en_due  = (m_phase == 2) && ((m_elapsed % period) == period - 1);
        exp_led = {(m_phase == 2 && m_kind == 0), (m_phase == 2 && m_kind == 1),
                   m_stopped, 3'(m_prog)};
        chk("f_clr", 6'(f_clr), 6'(m_phase == 1 && m_kind == 0));
        chk("t_clr", 6'(t_clr), 6'(m_phase == 1 && m_kind == 1));
        chk("f_en",  6'(f_en),  6'(en_due && m_kind == 0));
        chk("t_en",  6'(t_en),  6'(en_due && m_kind == 1));
        chk("sel_t", 6'(sel_t), 6'(m_sel));
        chk("led",   led,       exp_led);
    endtask

    // Drive one cycle of inputs, let the edge happen, then check outputs.
    task automatic tick(input logic sf = 0, st = 0, sp = 0, up = 0,
                        input logic [2:0] pg = 0, input logic ov = 0, dn = 0);
        start_f = sf; start_t = st; stop_f_t = sp; update = up; prog = pg;
        f_ovf = ov; t_done = dn;
        @(posedge clock);
        if (!reset) model_reset();
        else        model_step(sf, st, sp, up, pg, ov, dn);
        #1;
        start_f = 0; start_t = 0; stop_f_t = 0; update = 0; f_ovf = 0; t_done = 0;
        check_all();
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        // 1: reset held 3 cycles
        repeat (3) tick();
        reset = 1'b1;
        idle_n(2);
        // 2: program period 32, run Fibonacci
        tick(.up(1), .pg(3'd3));
        tick(.sf(1));
        idle_n(100);
        // 3: stop, display frozen
        tick(.sp(1));
        idle_n(50);
        // 4: timer run ended by t_done
        tick(.st(1));
        idle_n(80);
        tick(.dn(1));
        idle_n(5);
        // 5: update ignored mid-run, then honoured in idle
        tick(.sf(1));
        idle_n(40);
        tick(.up(1), .pg(3'd5));
        idle_n(60);
        tick(.sp(1));
        tick(.up(1), .pg(3'd5));
        tick(.sf(1));
        idle_n(300);
        tick(.ov(1));
        // 6: priority cases
        tick(.sf(1), .st(1));
        idle_n(4);
        tick(.sp(1));
        tick(.sp(1), .up(1), .pg(3'd2));
        tick(.up(1), .pg(3'd0));
        tick(.st(1));
        idle_n(20);
        // async reset in the middle of a timer run
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        idle_n(2);
        reset = 1'b1;
        idle_n(2);

        // randomized commands
        for (int i = 0; i < 4000; i++) begin
            logic sf, st, sp, up, ov, dn;
            logic [2:0] pg;
            sf = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 19) == 0);
            sp = ($urandom_range(0, 149) == 0);
            up = ($urandom_range(0, 29) == 0);
            pg = 3'($urandom_range(0, 7));
            ov = ($urandom_range(0, 199) == 0);
            dn = ($urandom_range(0, 199) == 0);
            tick(sf, st, sp, up, pg, ov, dn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
